// File: rtl/ms_timer_pkg.sv
// Shared types and constants for the millisecond timer arbiter.
package ms_timer_pkg;

  localparam int unsigned DefaultDurW = 16;

  localparam int unsigned ReqDispense = 0;
  localparam int unsigned ReqChange   = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/tick_edge_det.sv
// Turns the divided ~1 kHz square wave into a registered one-cycle strobe per rising edge.
module tick_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_in_i,
  output logic ms_tick_o
);

  logic tick_prev_q;
  logic ms_tick_q;

  // tick_prev resets high so a level already high out of reset is not seen as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_prev_q <= 1'b1;
      ms_tick_q   <= 1'b0;
    end else begin
      tick_prev_q <= tick_in_i;
      ms_tick_q   <= tick_in_i & ~tick_prev_q;
    end
  end

  assign ms_tick_o = ms_tick_q;

endmodule

// File: rtl/ms_timer_arbiter.sv
// Round-robin arbiter sharing one ms down-counter between the dispense and change-return timers.
module ms_timer_arbiter
  import ms_timer_pkg::*;
#(
  parameter int unsigned DUR_W = DefaultDurW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_in_i,
  input  logic [1:0]       req_i,
  input  logic [DUR_W-1:0] dur0_i,
  input  logic [DUR_W-1:0] dur1_i,
  output logic [1:0]       grant_o,
  output logic [1:0]       done_o,
  output logic             busy_o,
  output logic             ms_tick_o,
  output logic [DUR_W-1:0] remain_o
);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             ms_tick;
  logic             sel;
  logic             owner;

  tick_edge_det u_tick_edge_det (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tick_in_i (tick_in_i),
    .ms_tick_o (ms_tick)
  );

  assign owner = grant_q[ReqChange];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          sel     = (req_i == 2'b11) ? ptr_q : req_i[ReqChange];
          grant_d = sel ? 2'b10 : 2'b01;
          cnt_d   = sel ? dur1_i : dur0_i;
          state_d = StRun;
        end
      end
      StRun: begin
        // A dropped request cancels, even if the final strobe lands in the same cycle.
        if ((req_i & grant_q) == 2'b00) begin
          state_d = StIdle;
          grant_d = 2'b00;
          cnt_d   = '0;
          ptr_d   = ~owner;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else if (ms_tick) begin
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
        cnt_d   = '0;
        ptr_d   = ~owner;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o   = grant_q;
  assign done_o    = (state_q == StDone) ? grant_q : 2'b00;
  assign busy_o    = (state_q == StRun) || (state_q == StDone);
  assign ms_tick_o = ms_tick;
  assign remain_o  = cnt_q;

endmodule

// File: tb/tb_ms_timer_arbiter.sv
// Self-checking bench: vector table of timed requests plus hand sequences for reset corners.
module tb_ms_timer_arbiter;
  import ms_timer_pkg::*;

  localparam int unsigned DurW     = 16;
  localparam int unsigned TickHalf = 4;
  localparam int          Budget   = 2000;

  typedef struct {
    logic [1:0]      req;
    logic [DurW-1:0] d0;
    logic [DurW-1:0] d1;
    int              cancel_after;
    logic [1:0]      exp_grant;
    bit              hold;
  } vec_t;

  typedef struct packed {
    logic [1:0]      grant;
    logic [DurW-1:0] dur;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick_in = 1'b1;
  logic [1:0]      req = 2'b00;
  logic [DurW-1:0] dur0 = '0;
  logic [DurW-1:0] dur1 = '0;
  logic [1:0]      grant;
  logic [1:0]      done;
  logic            busy;
  logic            ms_tick;
  logic [DurW-1:0] remain;

  int   n_checks = 0;
  int   n_errors = 0;
  logic m_prev = 1'b1;
  logic m_ms = 1'b0;
  bit   tick_en = 1'b0;
  int   tick_div = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  ms_timer_arbiter #(
    .DUR_W (DurW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tick_in_i (tick_in),
    .req_i     (req),
    .dur0_i    (dur0),
    .dur1_i    (dur1),
    .grant_o   (grant),
    .done_o    (done),
    .busy_o    (busy),
    .ms_tick_o (ms_tick),
    .remain_o  (remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict the strobe from the tick level we drove, sample after the edge,
  // then advance the free-running square wave.
  task automatic cycle();
    @(posedge clk);
    m_ms   = rst ? 1'b0 : (tick_in & ~m_prev);
    m_prev = rst ? 1'b1 : tick_in;
    #1;
    chk("ms_tick", 32'(ms_tick), 32'(m_ms));
    if (tick_en) begin
      tick_div++;
      if (tick_div == TickHalf) begin
        tick_div = 0;
        tick_in  = ~tick_in;
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [DurW-1:0] dur;
    exp_t            e;
    int              rem;
    int              ticks;
    int              spent;
    logic            t;
    req  = v.req;
    dur0 = v.d0;
    dur1 = v.d1;
    dur  = v.exp_grant[1] ? v.d1 : v.d0;
    sb_q.push_back('{grant: v.exp_grant, dur: dur});
    cycle();
    chk("grant", 32'(grant), 32'(v.exp_grant));
    chk("busy_run", 32'(busy), 32'd1);
    chk("remain_load", 32'(remain), 32'(dur));
    // Counter is latched at grant, so scrambling the live duration must not matter.
    if (v.exp_grant[1]) dur1 = DurW'($urandom);
    else dur0 = DurW'($urandom);
    rem   = int'(dur);
    ticks = 0;
    spent = 0;
    while (rem != 0 && !(v.cancel_after >= 0 && ticks == v.cancel_after) && spent < Budget) begin
      t = m_ms;
      cycle();
      spent++;
      if (t) begin
        rem--;
        ticks++;
      end
      if (rem != 0) begin
        chk("remain_step", 32'(remain), 32'(rem));
        chk("no_early_done", 32'(done), 32'd0);
      end
    end
    if (spent >= Budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: got no done after %0d cycles, required one", spent);
    end
    e = sb_q.pop_front();
    if (v.cancel_after >= 0) begin
      req = 2'b00;
      cycle();
      chk("cancel_grant", 32'(grant), 32'd0);
      chk("cancel_done", 32'(done), 32'd0);
      chk("cancel_busy", 32'(busy), 32'd0);
      chk("cancel_remain", 32'(remain), 32'd0);
    end else begin
      if (dur == '0) cycle();
      chk("done", 32'(done), 32'(e.grant));
      chk("done_grant", 32'(grant), 32'(e.grant));
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_remain", 32'(remain), 32'd0);
      if (!v.hold) req = 2'b00;
      cycle();
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    // Pointer sequence: 0 -> (hand 01,10) 0 -> 1 -> 0 -> 1 -> 0 -> 1 -> 0
    vecs[0] = '{req: 2'b01, d0: 16'd3, d1: 16'd0, cancel_after: -1, exp_grant: 2'b01, hold: 0};
    vecs[1] = '{req: 2'b10, d0: 16'd0, d1: 16'd0, cancel_after: -1, exp_grant: 2'b10, hold: 0};
    vecs[2] = '{req: 2'b01, d0: 16'd5, d1: 16'd0, cancel_after: 2, exp_grant: 2'b01, hold: 0};
    vecs[3] = '{req: 2'b11, d0: 16'd1, d1: 16'd2, cancel_after: -1, exp_grant: 2'b10, hold: 0};
    vecs[4] = '{req: 2'b11, d0: 16'd2, d1: 16'd4, cancel_after: -1, exp_grant: 2'b01, hold: 0};
    vecs[5] = '{req: 2'b10, d0: 16'd7, d1: 16'd3, cancel_after: -1, exp_grant: 2'b10, hold: 0};
    vecs[6] = '{req: 2'b11, d0: 16'd1, d1: 16'd1, cancel_after: -1, exp_grant: 2'b01, hold: 0};

    // Reset with TickIn already high: no strobe may appear.
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_ms_quiet", 32'(ms_tick), 32'd0);
    end
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_remain", 32'(remain), 32'd0);
    tick_in = 1'b0;
    cycle();
    tick_in = 1'b1;
    cycle();
    chk("ms_pulse_hi", 32'(ms_tick), 32'd1);
    cycle();
    chk("ms_pulse_lo", 32'(ms_tick), 32'd0);
    tick_en = 1'b1;

    // Both requesting out of reset: 0 first, then back-to-back grant goes to 1.
    run_txn('{req: 2'b11, d0: 16'd2, d1: 16'd1, cancel_after: -1, exp_grant: 2'b01, hold: 1});
    run_txn('{req: 2'b11, d0: 16'd2, d1: 16'd1, cancel_after: -1, exp_grant: 2'b10, hold: 0});

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset in the middle of a long interval.
    req  = 2'b01;
    dur0 = 16'd100;
    cycle();
    chk("long_grant", 32'(grant), 32'd1);
    for (int i = 0; i < 20; i++) cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_remain", 32'(remain), 32'd0);
    chk("midrst_ms", 32'(ms_tick), 32'd0);
    rst = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 30; i++) begin
      cycle();
      chk("post_rst_no_done", 32'(done), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
